// File: rtl/debug_display_selector.sv
// debug_display_selector: routes one of N_CH debug words to the LEDs.
// Debounced channel-advance button, channel-index splash and freeze hold.

module debug_display_debounce #(
    parameter int unsigned CYCLES = 380000
) (
    input  logic sys_clk,
    input  logic resetn,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous input
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Accept a new level only once it has differed for CYCLES cycles
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(CYCLES - 1)) begin
            cnt   <= '0;
            level <= s2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

module debug_display_selector #(
    parameter int unsigned           N_CH            = 8,
    parameter int unsigned           DATA_WIDTH      = 16,
    parameter int unsigned           DEBOUNCE_CYCLES = 380000,
    parameter int unsigned           SHOW_IDX_CYCLES = 38000000,
    parameter logic [DATA_WIDTH-1:0] RESET_PATTERN   = 16'hAAAA
) (
    input  logic                       sys_clk,
    input  logic                       resetn,
    input  logic                       sel_button_n,
    input  logic                       freeze_n,
    input  logic [N_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [N_CH-1:0]            ch_valid,
    output logic [DATA_WIDTH-1:0]      debug_leds,
    output logic [$clog2(N_CH)-1:0]    sel_idx,
    output logic                       ch_changed
);

    localparam int unsigned SW = $clog2(N_CH);
    localparam int unsigned TW =
        (SHOW_IDX_CYCLES > 1) ? $clog2(SHOW_IDX_CYCLES) : 1;

    typedef enum logic [1:0] {
        WAIT_DATA,
        SHOW_IDX,
        LIVE,
        FROZEN
    } state_t;

    state_t                state;
    logic [TW-1:0]         timer;
    logic                  blank_hold;

    logic                  btn_level;
    logic                  btn_level_d;
    logic                  frz_level;
    logic                  press;

    logic [DATA_WIDTH-1:0] cur_data;
    logic                  cur_valid;
    logic [SW-1:0]         next_idx;
    logic [DATA_WIDTH-1:0] next_onehot;

    debug_display_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
        .sys_clk (sys_clk),
        .resetn  (resetn),
        .raw     (sel_button_n),
        .level   (btn_level)
    );

    debug_display_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_frz_db (
        .sys_clk (sys_clk),
        .resetn  (resetn),
        .raw     (freeze_n),
        .level   (frz_level)
    );

    // Delayed button level so a press is the accepted 1->0 edge only
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            btn_level_d <= 1'b1;
        end else begin
            btn_level_d <= btn_level;
        end
    end

    assign press = btn_level_d & ~btn_level;

    // Pick the word and strobe of the selected channel
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_idx == SW'(k)) begin
                cur_data  = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
                cur_valid = ch_valid[k];
            end
        end
    end

    assign next_idx    = (sel_idx == SW'(N_CH - 1)) ? '0 : sel_idx + SW'(1);
    assign next_onehot = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << next_idx;

    // Display state machine; press outranks freeze, freeze outranks sample
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state      <= WAIT_DATA;
            debug_leds <= RESET_PATTERN;
            sel_idx    <= '0;
            ch_changed <= 1'b0;
            timer      <= '0;
            blank_hold <= 1'b0;
        end else begin
            ch_changed <= 1'b0;
            if (press && state != FROZEN) begin
                sel_idx    <= next_idx;
                ch_changed <= 1'b1;
                debug_leds <= next_onehot;
                timer      <= '0;
                state      <= SHOW_IDX;
            end else begin
                unique case (state)
                    WAIT_DATA: begin
                        if (!frz_level) begin
                            state      <= FROZEN;
                            blank_hold <= 1'b1;
                        end else if (cur_valid) begin
                            debug_leds <= cur_data;
                            state      <= LIVE;
                        end
                    end
                    SHOW_IDX: begin
                        if (timer == TW'(SHOW_IDX_CYCLES - 1)) begin
                            debug_leds <= RESET_PATTERN;
                            state      <= WAIT_DATA;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    LIVE: begin
                        if (!frz_level) begin
                            state      <= FROZEN;
                            blank_hold <= 1'b0;
                        end else if (cur_valid) begin
                            debug_leds <= cur_data;
                        end
                    end
                    FROZEN: begin
                        if (frz_level) begin
                            state <= blank_hold ? WAIT_DATA : LIVE;
                        end
                    end
                    default: begin
                        state <= WAIT_DATA;
                    end
                endcase
            end
        end
    end

endmodule
